// File: rtl/reg_rename_file.sv
// Architectural register file with rename tags: per-register value, busy bit and
// producing RoB tag, with a same-cycle commit bypass on every read port.

module rrf_rd_port #(
    parameter int ROB_W = 4,
    parameter int XLEN  = 32
) (
    input  logic [4:0]                  addr_i,
    input  logic [31:0][XLEN-1:0]       value_i,
    input  logic [31:0]                 busy_i,
    input  logic [31:0][ROB_W-1:0]      tag_i,
    input  logic                        cmt_fire_i,
    input  logic [4:0]                  cmt_rd_i,
    input  logic [ROB_W-1:0]            cmt_tag_i,
    input  logic [XLEN-1:0]             cmt_value_i,
    output logic [XLEN-1:0]             value_o,
    output logic                        busy_o,
    output logic [ROB_W-1:0]            tag_o
);
    logic bypass;

    // Forward a commit that retires the pending producer this port is waiting on.
    assign bypass = cmt_fire_i && (cmt_rd_i == addr_i) && (addr_i != 5'd0)
                    && busy_i[addr_i] && (tag_i[addr_i] == cmt_tag_i);

    always_comb begin
        value_o = value_i[addr_i];
        busy_o  = busy_i[addr_i];
        tag_o   = busy_i[addr_i] ? tag_i[addr_i] : '0;
        if (bypass) begin
            value_o = cmt_value_i;
            busy_o  = 1'b0;
            tag_o   = '0;
        end
    end
endmodule

module reg_rename_file #(
    parameter int NUM_RD = 2,
    parameter int ROB_W  = 4,
    parameter int XLEN   = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rdy,
    input  logic                    flush,
    input  logic                    commit_en,
    input  logic [4:0]              commit_rd,
    input  logic [ROB_W-1:0]        commit_rob_id,
    input  logic [XLEN-1:0]         commit_value,
    input  logic                    issue_en,
    input  logic [4:0]              issue_rd,
    input  logic [ROB_W-1:0]        issue_rob_id,
    input  logic [NUM_RD*5-1:0]     rd_addr,
    output logic [NUM_RD*XLEN-1:0]  rd_value,
    output logic [NUM_RD-1:0]       rd_busy,
    output logic [NUM_RD*ROB_W-1:0] rd_tag,
    input  logic [4:0]              dbg_addr,
    output logic [XLEN-1:0]         dbg_value
);
    logic [31:0][XLEN-1:0]  value_q, value_d;
    logic [31:0]            busy_q, busy_d;
    logic [31:0][ROB_W-1:0] tag_q, tag_d;

    always_comb begin
        value_d = value_q;
        busy_d  = busy_q;
        tag_d   = tag_q;
        if (commit_en && commit_rd != 5'd0) begin
            value_d[commit_rd] = commit_value;
            // A mismatching tag means a newer producer is still in flight.
            if (busy_q[commit_rd] && tag_q[commit_rd] == commit_rob_id) begin
                busy_d[commit_rd] = 1'b0;
                tag_d[commit_rd]  = '0;
            end
        end
        // Issue is applied after commit so it wins on a same-register collision.
        if (flush) begin
            busy_d = '0;
            tag_d  = '0;
        end else if (issue_en && issue_rd != 5'd0) begin
            busy_d[issue_rd] = 1'b1;
            tag_d[issue_rd]  = issue_rob_id;
        end
        value_d[0] = '0;
        busy_d[0]  = 1'b0;
        tag_d[0]   = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value_q <= '0;
            busy_q  <= '0;
            tag_q   <= '0;
        end else if (rdy) begin
            value_q <= value_d;
            busy_q  <= busy_d;
            tag_q   <= tag_d;
        end
    end

    generate
        for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
            rrf_rd_port #(.ROB_W(ROB_W), .XLEN(XLEN)) u_port (
                .addr_i      (rd_addr[5*i +: 5]),
                .value_i     (value_q),
                .busy_i      (busy_q),
                .tag_i       (tag_q),
                .cmt_fire_i  (commit_en && rdy),
                .cmt_rd_i    (commit_rd),
                .cmt_tag_i   (commit_rob_id),
                .cmt_value_i (commit_value),
                .value_o     (rd_value[XLEN*i +: XLEN]),
                .busy_o      (rd_busy[i]),
                .tag_o       (rd_tag[ROB_W*i +: ROB_W])
            );
        end
    endgenerate

    assign dbg_value = value_q[dbg_addr];
endmodule

// File: tb/tb_reg_rename_file.sv
// Bench for reg_rename_file: directed vector table, reset corner cases, then
// random traffic checked against a rule-level register-file model.

module tb_reg_rename_file;
    localparam int NUM_RD = 2;
    localparam int ROB_W  = 4;
    localparam int XLEN   = 32;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    rdy, flush, commit_en, issue_en;
    logic [4:0]              commit_rd, issue_rd, dbg_addr;
    logic [ROB_W-1:0]        commit_rob_id, issue_rob_id;
    logic [XLEN-1:0]         commit_value;
    logic [NUM_RD*5-1:0]     rd_addr;
    logic [NUM_RD*XLEN-1:0]  rd_value;
    logic [NUM_RD-1:0]       rd_busy;
    logic [NUM_RD*ROB_W-1:0] rd_tag;
    logic [XLEN-1:0]         dbg_value;

    int n_total = 0;
    int n_pass  = 0;

    reg_rename_file #(.NUM_RD(NUM_RD), .ROB_W(ROB_W), .XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .commit_en(commit_en), .commit_rd(commit_rd), .commit_rob_id(commit_rob_id),
        .commit_value(commit_value), .issue_en(issue_en), .issue_rd(issue_rd),
        .issue_rob_id(issue_rob_id), .rd_addr(rd_addr), .rd_value(rd_value),
        .rd_busy(rd_busy), .rd_tag(rd_tag), .dbg_addr(dbg_addr), .dbg_value(dbg_value)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          r, f, ie, ce;
        int          ird, itag, crd, ctag, a, et;
        logic [31:0] cval, ev, edbg;
        bit          eb;
    } vec_t;

    vec_t tbl[27];

    // Rule-level model of the architectural state.
    logic [31:0] m_val [32];
    bit          m_busy[32];
    int          m_tag [32];

    function automatic vec_t mk(bit r, bit f, bit ie, int ird, int itag, bit ce, int crd,
                                int ctag, logic [31:0] cval, int a, logic [31:0] ev,
                                bit eb, int et, logic [31:0] edbg);
        vec_t v;
        v.r = r; v.f = f; v.ie = ie; v.ird = ird; v.itag = itag; v.ce = ce;
        v.crd = crd; v.ctag = ctag; v.cval = cval; v.a = a; v.ev = ev;
        v.eb = eb; v.et = et; v.edbg = edbg;
        return v;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        else
            n_pass++;
    endtask

    task automatic drive(bit r, bit f, bit ie, int ird, int itag, bit ce, int crd,
                         int ctag, logic [31:0] cval);
        rdy = r; flush = f; issue_en = ie; issue_rd = 5'(ird); issue_rob_id = ROB_W'(itag);
        commit_en = ce; commit_rd = 5'(crd); commit_rob_id = ROB_W'(ctag); commit_value = cval;
    endtask

    task automatic chk_port(string nm, int p, logic [31:0] ev, bit eb, int et);
        chk({nm, "_val"},  64'(rd_value[XLEN*p +: XLEN]), 64'(ev));
        chk({nm, "_busy"}, 64'(rd_busy[p]), 64'(eb));
        chk({nm, "_tag"},  64'(rd_tag[ROB_W*p +: ROB_W]), 64'(et));
    endtask

    task automatic model_apply();
        if (!rdy) return;
        if (commit_en && commit_rd != 0) begin
            m_val[commit_rd] = commit_value;
            if (m_busy[commit_rd] && m_tag[commit_rd] == int'(commit_rob_id)) begin
                m_busy[commit_rd] = 0;
                m_tag[commit_rd]  = 0;
            end
        end
        if (flush) begin
            foreach (m_busy[k]) begin m_busy[k] = 0; m_tag[k] = 0; end
        end else if (issue_en && issue_rd != 0) begin
            m_busy[issue_rd] = 1;
            m_tag[issue_rd]  = int'(issue_rob_id);
        end
    endtask

    initial begin
        tbl[0]  = mk(1,0,1,5,3, 0,0,0,0,            5, 0,0,0,0);
        tbl[1]  = mk(1,0,0,0,0, 0,0,0,0,            5, 0,1,3,0);
        tbl[2]  = mk(1,0,0,0,0, 1,5,3,32'hDEADBEEF, 5, 32'hDEADBEEF,0,0,0);
        tbl[3]  = mk(1,0,0,0,0, 0,0,0,0,            5, 32'hDEADBEEF,0,0,32'hDEADBEEF);
        tbl[4]  = mk(1,0,1,7,1, 0,0,0,0,            7, 0,0,0,0);
        tbl[5]  = mk(1,0,1,7,2, 0,0,0,0,            7, 0,1,1,0);
        tbl[6]  = mk(1,0,0,0,0, 1,7,1,32'h11,       7, 0,1,2,0);
        tbl[7]  = mk(1,0,0,0,0, 0,0,0,0,            7, 32'h11,1,2,32'h11);
        tbl[8]  = mk(1,0,1,9,4, 0,0,0,0,            9, 0,0,0,0);
        tbl[9]  = mk(1,0,1,9,4, 1,9,4,32'h22,       9, 32'h22,0,0,0);
        tbl[10] = mk(1,0,0,0,0, 0,0,0,0,            9, 32'h22,1,4,32'h22);
        tbl[11] = mk(1,0,1,3,6, 0,0,0,0,            3, 0,0,0,0);
        tbl[12] = mk(1,0,1,4,7, 0,0,0,0,            3, 0,1,6,0);
        tbl[13] = mk(1,1,1,6,5, 1,3,6,32'h33,       3, 32'h33,0,0,0);
        tbl[14] = mk(1,0,0,0,0, 0,0,0,0,            4, 0,0,0,0);
        tbl[15] = mk(1,0,0,0,0, 0,0,0,0,            6, 0,0,0,0);
        tbl[16] = mk(1,0,0,0,0, 0,0,0,0,            3, 32'h33,0,0,32'h33);
        tbl[17] = mk(1,0,0,0,0, 0,0,0,0,            7, 32'h11,0,0,32'h11);
        tbl[18] = mk(0,0,1,10,9,1,10,0,32'hAA,      10, 0,0,0,0);
        tbl[19] = mk(1,0,0,0,0, 0,0,0,0,            10, 0,0,0,0);
        tbl[20] = mk(1,0,1,0,1, 1,0,0,32'h55,       0, 0,0,0,0);
        tbl[21] = mk(1,0,0,0,0, 0,0,0,0,            0, 0,0,0,0);
        tbl[22] = mk(1,0,1,11,2,0,0,0,0,            11, 0,0,0,0);
        tbl[23] = mk(0,0,0,0,0, 1,11,2,32'h77,      11, 0,1,2,0);
        tbl[24] = mk(1,0,0,0,0, 0,0,0,0,            11, 0,1,2,0);
        tbl[25] = mk(1,0,0,0,0, 1,11,2,32'h78,      11, 32'h78,0,0,0);
        tbl[26] = mk(1,0,0,0,0, 0,0,0,0,            11, 32'h78,0,0,32'h78);

        rst = 1'b0;
        drive(1,0,0,0,0,0,0,0,0);
        rd_addr = {5'd5, 5'd5};
        dbg_addr = 5'd5;
        #2;
        chk_port("reset_p0", 0, 0, 0, 0);
        chk("reset_dbg", 64'(dbg_value), 0);
        @(negedge clk);
        rst = 1'b1;

        // Directed table: port 0 and port 1 read the same register.
        for (int i = 0; i < 27; i++) begin
            @(negedge clk);
            drive(tbl[i].r, tbl[i].f, tbl[i].ie, tbl[i].ird, tbl[i].itag,
                  tbl[i].ce, tbl[i].crd, tbl[i].ctag, tbl[i].cval);
            rd_addr  = {5'(tbl[i].a), 5'(tbl[i].a)};
            dbg_addr = 5'(tbl[i].a);
            #1;
            chk_port($sformatf("tbl%0d_p0", i), 0, tbl[i].ev, tbl[i].eb, tbl[i].et);
            chk_port($sformatf("tbl%0d_p1", i), 1, tbl[i].ev, tbl[i].eb, tbl[i].et);
            chk($sformatf("tbl%0d_dbg", i), 64'(dbg_value), 64'(tbl[i].edbg));
        end

        // Asynchronous reset in the middle of a low phase with traffic pending.
        @(negedge clk);
        drive(1,0,1,12,3,0,0,0,0);
        rd_addr = {5'd3, 5'd12};
        dbg_addr = 5'd3;
        @(negedge clk);
        drive(1,1,1,12,7,1,12,3,32'h99);
        #1;
        chk_port("pre_rst_x12", 0, 32'h99, 0, 0);
        #2;
        rst = 1'b0;
        #1;
        chk_port("async_rst_x12", 0, 0, 0, 0);
        chk_port("async_rst_x3", 1, 0, 0, 0);
        chk("async_rst_dbg", 64'(dbg_value), 0);
        @(negedge clk);
        chk_port("rst_hold_x12", 0, 0, 0, 0);
        drive(1,0,1,12,5,1,3,0,32'h44);
        rst = 1'b1;
        @(negedge clk);
        drive(1,0,0,0,0,0,0,0,0);
        #1;
        chk_port("rst_release_x12", 0, 0, 1, 5);
        chk_port("rst_release_x3", 1, 32'h44, 0, 0);

        foreach (m_val[k]) begin m_val[k] = 0; m_busy[k] = 0; m_tag[k] = 0; end
        m_busy[12] = 1; m_tag[12] = 5; m_val[3] = 32'h44;

        // Random traffic on a small register/tag window to force collisions.
        for (int c = 0; c < 400; c++) begin
            int crd, ctag;
            @(negedge clk);
            crd  = int'($urandom_range(0, 7));
            ctag = ($urandom_range(0, 1) == 1) ? m_tag[crd] : int'($urandom_range(0, 15));
            drive($urandom_range(0, 7) != 0, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 1) == 1, int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 15)), $urandom_range(0, 1) == 1,
                  crd, ctag, $urandom);
            rd_addr  = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            dbg_addr = 5'($urandom_range(0, 7));
            #1;
            for (int p = 0; p < NUM_RD; p++) begin
                int a;
                logic [31:0] ev;
                bit eb;
                int et;
                a  = int'(rd_addr[5*p +: 5]);
                ev = m_val[a]; eb = m_busy[a]; et = m_tag[a];
                if (rdy && commit_en && int'(commit_rd) == a && a != 0 &&
                    m_busy[a] && m_tag[a] == int'(commit_rob_id)) begin
                    ev = commit_value; eb = 0; et = 0;
                end
                chk_port($sformatf("rnd%0d_p%0d", c, p), p, ev, eb, et);
            end
            chk($sformatf("rnd%0d_dbg", c), 64'(dbg_value), 64'(m_val[dbg_addr]));
            model_apply();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/reg_rename_file.md
REG_RENAME_FILE -- requirements
Module: reg_rename_file

Interface
REQ-001 SHALL have parameter NUM_RD, default 2: number of independent operand read ports (1..4).
REQ-002 SHALL have parameter ROB_W, default 4: RoB tag width; tags range 0..2^ROB_W-1.
REQ-003 SHALL have parameter XLEN, default 32: register data width.
REQ-004 SHALL have ports:
  clk  in  1  single clock; all state updates on its rising edge.
  rst  in  1  asynchronous, active-low reset.
  rdy  in  1  stall when low: state frozen, reads still served.
  flush  in  1  RoB clear; drops all pending rename tags.
  commit_en  in  1  commit write valid.
  commit_rd  in  5  commit destination register.
  commit_rob_id  in  ROB_W  tag of the committing entry.
  commit_value  in  XLEN  committed result.
  issue_en  in  1  rename request valid.
  issue_rd  in  5  destination register being renamed.
  issue_rob_id  in  ROB_W  RoB tag allocated to the issuing instruction.
  rd_addr  in  NUM_RD*5  read addresses, port i at bits [5i+4:5i].
  rd_value  out  NUM_RD*XLEN  architectural value per port.
  rd_busy  out  NUM_RD  1 = value pending in RoB.
  rd_tag  out  NUM_RD*ROB_W  producing tag when busy, else 0.
  dbg_addr  in  5  debug read address.
  dbg_value  out  XLEN  architectural value of dbg_addr, no bypass.

Function
REQ-005 SHALL hold per register x1..x31: value (XLEN), busy (1), tag (ROB_W); x0 reads value 0, busy 0, tag 0 always.
REQ-006 SHALL ignore every write, issue, or commit targeting x0.
REQ-007 SHALL take effect only on edges with rdy=1; with rdy=0, value/busy/tag SHALL be unchanged regardless of other inputs.
REQ-008 Commit (commit_en=1, rdy=1): value[commit_rd] <= commit_value unconditionally; busy cleared only if busy=1 and tag==commit_rob_id.
REQ-009 Commit whose tag mismatches a busy register SHALL update value but leave busy/tag (newer producer pending).
REQ-010 Issue (issue_en=1, rdy=1, flush=0): busy[issue_rd] <= 1, tag[issue_rd] <= issue_rob_id.
REQ-011 Issue and commit to same rd in same cycle: value from commit; busy=1 and tag=issue_rob_id (issue wins).
REQ-012 Flush (flush=1, rdy=1): all busy and tag cleared to 0; same-cycle commit value write still applied; same-cycle issue dropped.
REQ-013 Reads SHALL be combinational and reflect state before the current edge's issue (instruction reading its own rd sees the old mapping).
REQ-014 Commit bypass: if commit_en=1, rdy=1, commit_rd==rd_addr[i]!=0, busy=1 and tag==commit_rob_id, port i SHALL output value=commit_value, busy=0, tag=0 in the same cycle.
REQ-015 No bypass when tag mismatches; port outputs stored value, busy=1, stored tag.
REQ-016 Bypass SHALL not depend on flush or issue inputs.
REQ-017 Writes SHALL become visible on stored-state reads one cycle after the edge (latency 1; bypass latency 0).
REQ-018 All NUM_RD ports SHALL be independent; equal addresses on several ports SHALL return identical results.
REQ-019 rd_tag SHALL be 0 whenever the corresponding rd_busy is 0.

Reset
REQ-020 rst low SHALL immediately (asynchronously) clear all values, busy bits and tags to 0; all outputs read 0.
REQ-021 rst low mid-operation SHALL override concurrent commit, issue and flush; release takes effect at the next rising edge, first update on that edge if rdy=1.

Verification
REQ-022 Issue x5 tag 3; next cycle read x5 -> busy=1, tag=3; commit x5 tag 3 value 0xDEADBEEF -> same-cycle bypass busy=0, value 0xDEADBEEF; next cycle stored same.
REQ-023 Issue x7 tag 1, then tag 2; commit x7 tag 1 value 0x11 -> value 0x11, busy=1, tag=2 retained.
REQ-024 Same cycle: issue x9 tag 4 and commit x9 tag 4 value 0x22 with read x9 -> read busy=0, value 0x22 (bypass); next cycle busy=1, tag=4, value 0x22.
REQ-025 Busy x3, x4; flush with issue x6 tag 5 and commit x3 value 0x33 -> all busy 0, x3=0x33, x6 not busy.
REQ-026 rdy=0 with issue/commit to x10 -> no state change; dbg_addr=10 unchanged; writes to x0 -> x0 reads 0.
REQ-027 Assert rst low mid-stream with busy registers -> all outputs 0 immediately, no edge required.
